// File: rtl/apb_cmd_master_if.sv
// Command/response channel plus APB3 bus bundle for apb_cmd_master.
// master = initiator side (the block), slave = command source / APB target side.
interface apb_cmd_master_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_error;
    logic              rsp_timeout;

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              pready;
    logic [DATA_W-1:0] prdata;
    logic              pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
        input  rsp_ready,
        output psel, penable, pwrite, paddr, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
        output rsp_ready,
        input  psel, penable, pwrite, paddr, pwdata,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_cmd_master.sv
// APB3 initiator: one valid/ready command in, one SETUP/ACCESS transfer out,
// one registered response back (read data, slave error, timeout abort).
module apb_cmd_master #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    apb_cmd_master_if.master   bus
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t              state_reg;
    logic [CNT_W-1:0]    wait_cnt_reg;
    logic                psel_reg;
    logic                penable_reg;
    logic                pwrite_reg;
    logic [ADDR_W-1:0]   paddr_reg;
    logic [DATA_W-1:0]   pwdata_reg;
    logic                rsp_valid_reg;
    logic [DATA_W-1:0]   rsp_rdata_reg;
    logic                rsp_error_reg;
    logic                rsp_timeout_reg;
    logic                timeout_hit;

    // Hit on the TIMEOUT-th consecutive ACCESS cycle without PREADY; never when TIMEOUT is 0.
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_reg == CNT_W'(TIMEOUT - 1));

    assign bus.cmd_ready   = (state_reg == IDLE);
    assign bus.psel        = psel_reg;
    assign bus.penable     = penable_reg;
    assign bus.pwrite      = pwrite_reg;
    assign bus.paddr       = paddr_reg;
    assign bus.pwdata      = pwdata_reg;
    assign bus.rsp_valid   = rsp_valid_reg;
    assign bus.rsp_rdata   = rsp_rdata_reg;
    assign bus.rsp_error   = rsp_error_reg;
    assign bus.rsp_timeout = rsp_timeout_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg       <= IDLE;
            wait_cnt_reg    <= '0;
            psel_reg        <= 1'b0;
            penable_reg     <= 1'b0;
            pwrite_reg      <= 1'b0;
            paddr_reg       <= '0;
            pwdata_reg      <= '0;
            rsp_valid_reg   <= 1'b0;
            rsp_rdata_reg   <= '0;
            rsp_error_reg   <= 1'b0;
            rsp_timeout_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        if (bus.cmd_addr[1:0] != 2'b00) begin
                            // Misaligned: answer with an error without touching the bus.
                            rsp_valid_reg   <= 1'b1;
                            rsp_rdata_reg   <= '0;
                            rsp_error_reg   <= 1'b1;
                            rsp_timeout_reg <= 1'b0;
                            state_reg       <= RESP;
                        end else begin
                            // The APB address/data registers double as the command latch.
                            paddr_reg    <= bus.cmd_addr;
                            pwrite_reg   <= bus.cmd_write;
                            pwdata_reg   <= bus.cmd_wdata;
                            psel_reg     <= 1'b1;
                            penable_reg  <= 1'b0;
                            wait_cnt_reg <= '0;
                            state_reg    <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    penable_reg <= 1'b1;
                    state_reg   <= ACCESS;
                end
                ACCESS: begin
                    if (bus.pready) begin
                        psel_reg        <= 1'b0;
                        penable_reg     <= 1'b0;
                        rsp_valid_reg   <= 1'b1;
                        rsp_rdata_reg   <= pwrite_reg ? '0 : bus.prdata;
                        rsp_error_reg   <= bus.pslverr;
                        rsp_timeout_reg <= 1'b0;
                        state_reg       <= RESP;
                    end else if (timeout_hit) begin
                        psel_reg        <= 1'b0;
                        penable_reg     <= 1'b0;
                        rsp_valid_reg   <= 1'b1;
                        rsp_rdata_reg   <= '0;
                        rsp_error_reg   <= 1'b1;
                        rsp_timeout_reg <= 1'b1;
                        state_reg       <= RESP;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_reg   <= 1'b0;
                        rsp_rdata_reg   <= '0;
                        rsp_error_reg   <= 1'b0;
                        rsp_timeout_reg <= 1'b0;
                        state_reg       <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_cmd_master.sv
// Randomized bench for apb_cmd_master: a transaction-level model predicts latency,
// APB phase counts and response fields for each command; the bench also plays the APB slave.
module tb_apb_cmd_master;
    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   txn_id = 0;

    always #5 clk = ~clk;

    apb_cmd_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    apb_cmd_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One command end to end. waits = PREADY-low ACCESS cycles before completion,
    // stuck = PREADY never rises, rdly = cycles the response is back-pressured.
    task automatic do_txn(input bit wr, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                          input int waits, input bit stuck, input bit slverr,
                          input logic [DATA_W-1:0] rdata, input int rdly);
        bit               misal;
        bit               tmo;
        int               exp_acc;
        int               exp_lat;
        logic [DATA_W-1:0] exp_rdata;
        bit               exp_err;
        int               setups;
        int               accs;
        int               bad;
        int               lat;

        misal     = (addr % 4) != 0;
        tmo       = !misal && (stuck || waits >= TIMEOUT);
        exp_acc   = misal ? 0 : (tmo ? TIMEOUT : waits + 1);
        exp_lat   = misal ? 1 : 2 + exp_acc;
        exp_rdata = (misal || tmo || wr) ? '0 : rdata;
        exp_err   = misal || tmo || slverr;
        setups = 0; accs = 0; bad = 0;

        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        bus.rsp_ready = (rdly == 0);
        check_eq("cmd_ready_idle", bus.cmd_ready, 1);
        step();
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = ADDR_W'($urandom);
        bus.cmd_wdata = $urandom;
        bus.cmd_write = ~wr;
        lat = 1;

        while (!bus.rsp_valid && lat < 64) begin
            bus.pready  = 1'b0;
            bus.pslverr = 1'($urandom);
            bus.prdata  = $urandom;
            if (bus.cmd_ready) bad++;
            if (bus.psel) begin
                if (bus.paddr !== addr || bus.pwrite !== wr || bus.pwdata !== wdata) bad++;
                if (!bus.penable) setups++;
                else begin
                    accs++;
                    if (!stuck && accs - 1 == waits) begin
                        bus.pready  = 1'b1;
                        bus.pslverr = slverr;
                        bus.prdata  = rdata;
                    end
                end
            end else if (bus.penable) bad++;
            step();
            lat++;
        end
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;

        check_eq("rsp_latency", lat, exp_lat);
        check_eq("rsp_rdata", bus.rsp_rdata, exp_rdata);
        check_eq("rsp_error", bus.rsp_error, exp_err);
        check_eq("rsp_timeout", bus.rsp_timeout, tmo);
        check_eq("psel_in_resp", bus.psel, 0);
        check_eq("setup_cycles", setups, misal ? 0 : 1);
        check_eq("access_cycles", accs, exp_acc);

        for (int d = 0; d < rdly; d++) begin
            step();
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== exp_rdata || bus.rsp_error !== exp_err ||
                bus.rsp_timeout !== tmo || bus.cmd_ready !== 1'b0 || bus.psel !== 1'b0) bad++;
        end
        check_eq("apb_and_hold", bad, 0);
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        check_eq("rsp_consumed", bus.rsp_valid, 0);
        check_eq("cmd_ready_after", bus.cmd_ready, 1);

        txn_id++;
        $display("txn %0d %s addr=0x%03h waits=%0d stuck=%0d slverr=%0d rdly=%0d lat=%0d rdata=0x%08h err=%0d tmo=%0d",
                 txn_id, wr ? "WR" : "RD", addr, waits, stuck, slverr, rdly, lat,
                 bus.rsp_rdata, exp_err, tmo);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;
        bus.pready    = 1'b0;
        bus.prdata    = '0;
        bus.pslverr   = 1'b0;

        repeat (3) step();
        check_eq("rst_psel", bus.psel, 0);
        check_eq("rst_penable", bus.penable, 0);
        check_eq("rst_rsp_valid", bus.rsp_valid, 0);
        check_eq("rst_paddr", bus.paddr, 0);
        check_eq("rst_cmd_ready", bus.cmd_ready, 1);
        rst_n = 1'b1;
        step();

        do_txn(1'b1, 12'h004, 32'h0000_0010, 0, 1'b0, 1'b0, 32'h0,         0);
        do_txn(1'b0, 12'h00C, 32'h0,         2, 1'b0, 1'b0, 32'h0000_000A, 1);
        do_txn(1'b1, 12'h000, 32'h1234_5678, 0, 1'b0, 1'b1, 32'h0,         0);
        do_txn(1'b0, 12'h014, 32'h0,         0, 1'b1, 1'b0, 32'hDEAD_BEEF, 0);
        do_txn(1'b1, 12'h006, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, 32'h0,         0);
        do_txn(1'b0, 12'h008, 32'h0,         1, 1'b0, 1'b0, 32'hA5A5_0001, 3);
        do_txn(1'b0, 12'h010, 32'h0,        15, 1'b0, 1'b1, 32'h0000_BEEF, 0);

        // Reset pulse while the transfer sits in ACCESS.
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 12'h010;
        step();
        bus.cmd_valid = 1'b0;
        repeat (3) step();
        check_eq("pre_rst_penable", bus.penable, 1);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_psel", bus.psel, 0);
        check_eq("async_rst_penable", bus.penable, 0);
        check_eq("async_rst_rsp_valid", bus.rsp_valid, 0);
        step();
        rst_n = 1'b1;
        step();
        check_eq("post_rst_cmd_ready", bus.cmd_ready, 1);
        check_eq("post_rst_rsp_valid", bus.rsp_valid, 0);

        for (int n = 0; n < 40; n++) begin
            logic [ADDR_W-1:0] a;
            a = ADDR_W'($urandom_range(0, 1023) * 4);
            if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
            do_txn(1'($urandom), a, $urandom, $urandom_range(0, 4), $urandom_range(0, 7) == 0,
                   1'($urandom), $urandom, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
